// File: rtl/acc_cpu_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : acc_cpu_control_unit
// Brief    : Multi-cycle fetch/decode/execute sequencer for the accumulator
//            CPU. Owns PC/IR/MBR/AC, drives the sync RAM and the ALU.
//            Optional SINGLE_STEP_EN adds a step input that gates each fetch.
// Revision : 1.0 - initial release
// ============================================================================
module acc_cpu_control_unit #(
    parameter int                    ADDR_WIDTH = 28,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = 'h100,
    parameter logic [3:0]            ALU_ADD    = 4'b0010,
    parameter logic [3:0]            ALU_SUB    = 4'b0110
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
`ifdef SINGLE_STEP_EN
    input  logic                  step,
`endif
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [DATA_WIDTH-1:0] alu_left,
    output logic [DATA_WIDTH-1:0] alu_right,
    output logic [3:0]            alu_sel,
    input  logic [DATA_WIDTH-1:0] alu_out,
    output logic                  busy,
    output logic                  halted,
    output logic                  illegal,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] ac
);

    localparam logic [3:0] c_OP_ADD   = 4'h0;
    localparam logic [3:0] c_OP_HALT  = 4'h1;
    localparam logic [3:0] c_OP_LOAD  = 4'h2;
    localparam logic [3:0] c_OP_STORE = 4'h3;
    localparam logic [3:0] c_OP_SUB   = 4'h4;
    localparam logic [3:0] c_OP_SKIP  = 4'h5;
    localparam logic [3:0] c_OP_JUMP  = 4'h6;
    localparam logic [3:0] c_OP_CLEAR = 4'h7;
    localparam logic [ADDR_WIDTH-1:0] c_PC_ONE = 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_F1,
        S_F2,
        S_DEC,
        S_E1,
        S_E2,
        S_E3,
        S_ST_EX,
        S_HALTED
`ifdef SINGLE_STEP_EN
        , S_STEP_WAIT
`endif
    } state_t;

    // Where control goes once an instruction has completed.
`ifdef SINGLE_STEP_EN
    localparam state_t c_RESUME = S_STEP_WAIT;
`else
    localparam state_t c_RESUME = S_F1;
`endif

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_ir;
    logic [DATA_WIDTH-1:0] r_mbr;
    logic [DATA_WIDTH-1:0] r_ac;
    logic                  r_illegal;

    logic [3:0]            w_opcode;
    logic [ADDR_WIDTH-1:0] w_operand;
    logic                  w_ac_neg;
    logic                  w_ac_zero;
    logic                  w_skip;

    assign w_opcode  = r_ir[DATA_WIDTH-1 -: 4];
    assign w_operand = r_ir[ADDR_WIDTH-1:0];
    assign w_ac_neg  = r_ac[DATA_WIDTH-1];
    assign w_ac_zero = (r_ac == '0);

    always_comb begin
        w_skip = 1'b0;
        case (r_ir[1:0])
            2'b00:   w_skip = w_ac_neg;
            2'b01:   w_skip = w_ac_zero;
            2'b10:   w_skip = !w_ac_neg && !w_ac_zero;
            default: w_skip = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        ram_addr  = '0;
        ram_cs    = 1'b0;
        ram_we    = 1'b0;
        ram_oe    = 1'b0;
        ram_wdata = '0;
        alu_left  = '0;
        alu_right = '0;
        alu_sel   = 4'b0000;
        busy      = 1'b1;
        halted    = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_F1;
            end
            S_HALTED: begin
                busy   = 1'b0;
                halted = 1'b1;
                if (start) w_next = S_F1;
            end
            S_F1: begin
                ram_addr = r_pc;
                ram_cs   = 1'b1;
                ram_oe   = 1'b1;
                w_next   = S_F2;
            end
            S_F2: w_next = S_DEC;
            S_DEC: begin
                case (w_opcode)
                    c_OP_ADD, c_OP_LOAD, c_OP_SUB:    w_next = S_E1;
                    c_OP_STORE:                       w_next = S_ST_EX;
                    c_OP_HALT:                        w_next = S_HALTED;
                    c_OP_JUMP, c_OP_CLEAR, c_OP_SKIP: w_next = c_RESUME;
                    default:                          w_next = S_HALTED;
                endcase
            end
            S_E1: begin
                ram_addr = w_operand;
                ram_cs   = 1'b1;
                ram_oe   = 1'b1;
                w_next   = S_E2;
            end
            S_E2: w_next = S_E3;
            S_E3: begin
                if (w_opcode == c_OP_ADD || w_opcode == c_OP_SUB) begin
                    alu_left  = r_ac;
                    alu_right = r_mbr;
                    alu_sel   = (w_opcode == c_OP_ADD) ? ALU_ADD : ALU_SUB;
                end
                w_next = c_RESUME;
            end
            S_ST_EX: begin
                ram_addr  = w_operand;
                ram_wdata = r_ac;
                ram_cs    = 1'b1;
                ram_we    = 1'b1;
                w_next    = c_RESUME;
            end
`ifdef SINGLE_STEP_EN
            S_STEP_WAIT: begin
                if (step) w_next = S_F1;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc      <= '0;
            r_ir      <= '0;
            r_mbr     <= '0;
            r_ac      <= '0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        r_pc      <= START_ADDR;
                        r_illegal <= 1'b0;
                    end
                end
                S_F2: begin
                    r_ir <= ram_rdata;
                    r_pc <= r_pc + c_PC_ONE;
                end
                S_DEC: begin
                    if (w_opcode == c_OP_JUMP) r_pc <= w_operand;
                    if (w_opcode == c_OP_CLEAR) r_ac <= '0;
                    if (w_opcode == c_OP_SKIP && w_skip) r_pc <= r_pc + c_PC_ONE;
                    if (w_opcode[3]) r_illegal <= 1'b1;
                end
                S_E2: r_mbr <= ram_rdata;
                S_E3: begin
                    if (w_opcode == c_OP_LOAD) begin
                        r_ac <= r_mbr;
                    end else if (w_opcode == c_OP_ADD || w_opcode == c_OP_SUB) begin
                        r_ac <= alu_out;
                    end
                end
                default: ;
            endcase
        end
    end

    assign illegal = r_illegal;
    assign pc      = r_pc;
    assign ac      = r_ac;

endmodule
`default_nettype wire
